// File: rtl/data_axi_bridge_if.sv
// Bundles the CPU data-side sram-like port and the single-beat AXI4 master channels.
// The master modport is the bridge; the slave modport is the CPU/interconnect side.
interface data_axi_bridge_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;

  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  modport master (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output araddr, arsize, arvalid, input arready,
    input  rdata, rvalid, output rready,
    output awaddr, awsize, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bvalid, output bready
  );

  modport slave (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  araddr, arsize, arvalid, output arready,
    output rdata, rvalid, input rready,
    input  awaddr, awsize, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bvalid, input bready
  );
endinterface

// File: rtl/data_axi_bridge.sv
// sram-like data port to single-beat AXI4 master bridge; one transaction in flight.
// All AXI valids/readies decode from state, so an async reset drops them immediately.
module data_axi_bridge (
  input  logic            clk,
  input  logic            rst,
  data_axi_bridge_if.master bus
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_ADDR = 3'd1;
  localparam logic [2:0] RD_DATA = 3'd2;
  localparam logic [2:0] WR_REQ  = 3'd3;
  localparam logic [2:0] WR_RESP = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;

  logic awvalid, wvalid, aw_now, w_now;
  logic [3:0] strb;

  assign awvalid = (state_q == WR_REQ) && !aw_done_q;
  assign wvalid  = (state_q == WR_REQ) && !w_done_q;
  assign aw_now  = aw_done_q || (awvalid && bus.awready);
  assign w_now   = w_done_q  || (wvalid  && bus.wready);

  // Size 3 is not a legal sram-like size; strobe it as a full word.
  always_comb begin
    strb = 4'b1111;
    case (size_q)
      2'd0: strb = 4'b0001 << addr_q[1:0];
      2'd1: strb = addr_q[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: if (bus.data_req) begin
        addr_d  = bus.data_addr;
        wdata_d = bus.data_wdata;
        size_d  = bus.data_size;
        state_d = bus.data_wr ? WR_REQ : RD_ADDR;
      end
      RD_ADDR: if (bus.arready) state_d = RD_DATA;
      RD_DATA: if (bus.rvalid)  state_d = IDLE;
      WR_REQ: begin
        if (aw_now && w_now) begin
          state_d   = WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_now;
          w_done_d  = w_now;
        end
      end
      WR_RESP: if (bus.bvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign bus.data_addr_ok = (state_q == IDLE) && bus.data_req;
  assign bus.data_data_ok = ((state_q == RD_DATA) && bus.rvalid) ||
                            ((state_q == WR_RESP) && bus.bvalid);
  assign bus.data_rdata   = ((state_q == RD_DATA) && bus.rvalid) ? bus.rdata : 32'd0;

  assign bus.araddr  = addr_q;
  assign bus.arsize  = {1'b0, size_q};
  assign bus.arvalid = (state_q == RD_ADDR);
  assign bus.rready  = (state_q == RD_DATA);

  assign bus.awaddr  = addr_q;
  assign bus.awsize  = {1'b0, size_q};
  assign bus.awvalid = awvalid;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = strb;
  assign bus.wlast   = wvalid;
  assign bus.wvalid  = wvalid;
  assign bus.bready  = (state_q == WR_RESP);
endmodule

// File: tb/tb_data_axi_bridge.sv
// Cycle-by-cycle directed vectors for data_axi_bridge: each record drives one cycle of
// CPU/slave inputs and lists the outputs expected in that same cycle.
module tb_data_axi_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_axi_bridge_if bus();
  data_axi_bridge dut (.clk(clk), .rst(rst), .bus(bus));

  // flag order: {addr_ok, data_ok, arvalid, rready, awvalid, wvalid, bready}
  localparam logic [6:0] AOK = 7'b1000000, DOK = 7'b0100000, AR = 7'b0010000,
                         RR  = 7'b0001000, AW  = 7'b0000100, WV = 7'b0000010,
                         BR  = 7'b0000001, NON = 7'b0000000;

  typedef struct {
    logic        rst, req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        arready, rvalid;
    logic [31:0] rdata;
    logic        awready, wready, bvalid;
    logic [6:0]  ef;
    logic [31:0] ea;
    logic [2:0]  es;
    logic [3:0]  est;
    logic [31:0] ed;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  function automatic vec_t v(input logic r, rq, w, input logic [1:0] sz,
                             input logic [31:0] a, wd, input logic arr, rv,
                             input logic [31:0] rd, input logic awr, wrd, bv,
                             input logic [6:0] ef, input logic [31:0] ea,
                             input logic [2:0] es, input logic [3:0] est,
                             input logic [31:0] ed);
    vec_t t;
    t.rst = r; t.req = rq; t.wr = w; t.size = sz; t.addr = a; t.wdata = wd;
    t.arready = arr; t.rvalid = rv; t.rdata = rd; t.awready = awr;
    t.wready = wrd; t.bvalid = bv; t.ef = ef; t.ea = ea; t.es = es;
    t.est = est; t.ed = ed;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step(input vec_t t, input string tag);
    @(posedge clk); #1;
    rst = t.rst;
    bus.data_req = t.req; bus.data_wr = t.wr; bus.data_size = t.size;
    bus.data_addr = t.addr; bus.data_wdata = t.wdata;
    bus.arready = t.arready; bus.rvalid = t.rvalid; bus.rdata = t.rdata;
    bus.awready = t.awready; bus.wready = t.wready; bus.bvalid = t.bvalid;
    @(negedge clk);
    chk({tag, " flags"}, 80'({bus.data_addr_ok, bus.data_data_ok, bus.arvalid, bus.rready,
                              bus.awvalid, bus.wvalid, bus.bready}), 80'(t.ef));
    if (t.ef[4]) chk({tag, " ar"}, 80'({bus.araddr, bus.arsize}), 80'({t.ea, t.es}));
    if (t.ef[2]) chk({tag, " aw"}, 80'({bus.awaddr, bus.awsize}), 80'({t.ea, t.es}));
    if (t.ef[1]) chk({tag, " w"}, 80'({bus.wlast, bus.wstrb, bus.wdata}), 80'({1'b1, t.est, t.ed}));
    if (t.ef[5] && t.ef[3]) chk({tag, " rdata"}, 80'(bus.data_rdata), 80'(t.ed));
  endtask

  initial begin
    bus.data_req = 0; bus.data_wr = 0; bus.data_size = 0; bus.data_addr = 0;
    bus.data_wdata = 0; bus.arready = 0; bus.rvalid = 0; bus.rdata = 0;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0;

    // reset and idle
    tbl.push_back(v(1,0,0,0,0,0, 0,0,0, 0,0,0, NON,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0, 0,0,0, NON,0,0,0,0));
    // word read, zero-wait slave
    tbl.push_back(v(0,1,0,2,32'h1000_0004,0, 1,0,0, 0,0,0, AOK,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 1,0,0, 0,0,0, AR,32'h1000_0004,3'd2,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,1,32'hDEAD_BEEF, 0,0,0, DOK|RR,0,0,0,32'hDEAD_BEEF));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0, 0,0,0, NON,0,0,0,0));
    // byte write to lane 3
    tbl.push_back(v(0,1,1,0,32'h2000_0003,32'hAB00_0000, 0,0,0, 0,0,0, AOK,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0, 1,1,0, AW|WV,32'h2000_0003,3'd0,4'b1000,32'hAB00_0000));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0, 0,0,1, DOK|BR,0,0,0,0));
    // halfword write, upper half
    tbl.push_back(v(0,1,1,1,32'h2000_0002,32'h5678_0000, 0,0,0, 0,0,0, AOK,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0, 1,1,0, AW|WV,32'h2000_0002,3'd1,4'b1100,32'h5678_0000));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0, 0,0,1, DOK|BR,0,0,0,0));
    // halfword write, lower half
    tbl.push_back(v(0,1,1,1,32'h2000_0010,32'h0000_9ABC, 0,0,0, 0,0,0, AOK,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0, 1,1,0, AW|WV,32'h2000_0010,3'd1,4'b0011,32'h0000_9ABC));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0, 0,0,1, DOK|BR,0,0,0,0));
    // byte write to lane 1
    tbl.push_back(v(0,1,1,0,32'h2000_0001,32'h0000_CD00, 0,0,0, 0,0,0, AOK,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0, 1,1,0, AW|WV,32'h2000_0001,3'd0,4'b0010,32'h0000_CD00));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0, 0,0,1, DOK|BR,0,0,0,0));
    // word write, then size 3 behaving as a word strobe
    tbl.push_back(v(0,1,1,2,32'h3000_0000,32'h0102_0304, 0,0,0, 0,0,0, AOK,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0, 1,1,0, AW|WV,32'h3000_0000,3'd2,4'b1111,32'h0102_0304));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0, 0,0,1, DOK|BR,0,0,0,0));
    tbl.push_back(v(0,1,1,3,32'h3000_0004,32'hFFEE_DDCC, 0,0,0, 0,0,0, AOK,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0, 1,1,0, AW|WV,32'h3000_0004,3'd3,4'b1111,32'hFFEE_DDCC));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0, 0,0,1, DOK|BR,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0, 0,0,0, 0,0,0, NON,0,0,0,0));

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // awready late by 3 cycles, wready immediate
    step(v(0,1,1,2,32'h4000_0000,32'h1122_3344, 0,0,0, 0,0,0, AOK,0,0,0,0), "awlate0");
    step(v(0,0,0,0,0,0, 0,0,0, 0,1,0, AW|WV,32'h4000_0000,3'd2,4'b1111,32'h1122_3344), "awlate1");
    step(v(0,0,0,0,0,0, 0,0,0, 0,1,1, AW,32'h4000_0000,3'd2,0,0), "awlate2");
    step(v(0,0,0,0,0,0, 0,0,0, 0,0,0, AW,32'h4000_0000,3'd2,0,0), "awlate3");
    step(v(0,0,0,0,0,0, 0,0,0, 1,0,0, AW,32'h4000_0000,3'd2,0,0), "awlate4");
    step(v(0,0,0,0,0,0, 0,0,0, 0,0,0, BR,0,0,0,0), "awlate5");
    step(v(0,0,0,0,0,0, 0,0,0, 0,0,1, DOK|BR,0,0,0,0), "awlate6");
    step(v(0,0,0,0,0,0, 0,0,0, 0,0,0, NON,0,0,0,0), "awlate7");

    // wready late by 2 cycles, awready immediate
    step(v(0,1,1,0,32'h4000_0102,32'h0077_0000, 0,0,0, 0,0,0, AOK,0,0,0,0), "wlate0");
    step(v(0,0,0,0,0,0, 0,0,0, 1,0,0, AW|WV,32'h4000_0102,3'd0,4'b0100,32'h0077_0000), "wlate1");
    step(v(0,0,0,0,0,0, 0,0,0, 1,0,0, WV,0,0,4'b0100,32'h0077_0000), "wlate2");
    step(v(0,0,0,0,0,0, 0,0,0, 0,1,0, WV,0,0,4'b0100,32'h0077_0000), "wlate3");
    step(v(0,0,0,0,0,0, 0,0,0, 0,0,1, DOK|BR,0,0,0,0), "wlate4");

    // read with late arready and rvalid 5 cycles late, req held high, then a write
    step(v(0,1,0,2,32'h5000_0008,0, 0,1,0, 0,0,0, AOK,0,0,0,0), "rdlate0");
    step(v(0,1,0,2,32'h5000_0008,0, 0,1,0, 0,0,1, AR,32'h5000_0008,3'd2,0,0), "rdlate1");
    step(v(0,1,0,2,32'h5000_0008,0, 1,0,0, 0,0,0, AR,32'h5000_0008,3'd2,0,0), "rdlate2");
    for (int k = 0; k < 5; k++)
      step(v(0,1,1,2,32'h6000_0000,32'hA5A5_5A5A, 0,0,0, 0,0,(k == 2), RR,0,0,0,0),
           $sformatf("rdwait%0d", k));
    step(v(0,1,1,2,32'h6000_0000,32'hA5A5_5A5A, 0,1,32'hCAFE_F00D, 0,0,0, DOK|RR,0,0,0,32'hCAFE_F00D), "rdlate3");
    step(v(0,1,1,2,32'h6000_0000,32'hA5A5_5A5A, 0,0,0, 0,0,0, AOK,0,0,0,0), "b2b0");
    step(v(0,1,1,2,32'h6000_0000,32'hA5A5_5A5A, 0,0,0, 1,1,0, AW|WV,32'h6000_0000,3'd2,4'b1111,32'hA5A5_5A5A), "b2b1");
    step(v(0,0,0,0,0,0, 0,0,0, 0,0,1, DOK|BR,0,0,0,0), "b2b2");

    // reset asserted mid-cycle while waiting for read data
    step(v(0,1,0,2,32'h7000_0000,0, 0,0,0, 0,0,0, AOK,0,0,0,0), "rstrd0");
    step(v(0,0,0,0,0,0, 1,0,0, 0,0,0, AR,32'h7000_0000,3'd2,0,0), "rstrd1");
    step(v(0,0,0,0,0,0, 0,0,0, 0,0,0, RR,0,0,0,0), "rstrd2");
    step(v(1,0,0,0,0,0, 0,1,32'h1234_5678, 0,0,0, NON,0,0,0,0), "rstrd3");
    step(v(0,1,0,1,32'h7000_0042,0, 1,0,0, 0,0,0, AOK,0,0,0,0), "rstrd4");
    step(v(0,0,0,0,0,0, 1,0,0, 0,0,0, AR,32'h7000_0042,3'd1,0,0), "rstrd5");
    step(v(0,0,0,0,0,0, 0,1,32'h8765_4321, 0,0,0, DOK|RR,0,0,0,32'h8765_4321), "rstrd6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
